// File: rtl/pc_new_mux.sv
// Next-PC selection for the fetch stage, plus the architectural PC register.
// pc_new is purely combinational and never depends on clk or rst_n.
module pc_new_mux #(
    parameter int                 ADDR_W       = 8,
    parameter logic [ADDR_W-1:0]  PC_RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_en,
    input  logic              pc_src,
    input  logic [1:0]        pc_in_sel,
    input  logic [ADDR_W-1:0] pc_plus_1,
    input  logic [ADDR_W-1:0] interrupt_addr,
    input  logic [ADDR_W-1:0] stack_addr,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic [ADDR_W-1:0] reset_addr,
    output logic [ADDR_W-1:0] pc_new,
    output logic [ADDR_W-1:0] pc
);

    // Unknown selects fall into the defaults and drive X rather than quietly picking a source.
    always_comb begin
        pc_new = {ADDR_W{1'bx}};
        case (pc_src)
            1'b0: pc_new = pc_plus_1;
            1'b1: begin
                case (pc_in_sel)
                    2'b00:   pc_new = interrupt_addr;
                    2'b01:   pc_new = stack_addr;
                    2'b10:   pc_new = branch_addr;
                    2'b11:   pc_new = reset_addr;
                    default: pc_new = {ADDR_W{1'bx}};
                endcase
            end
            default: pc_new = {ADDR_W{1'bx}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RESET_VAL;
        end else if (pc_en) begin
            pc <= pc_new;
        end
    end

endmodule

// File: tb/tb_pc_new_mux.sv
// Self-checking bench for pc_new_mux: directed plan cases followed by randomized
// cycles checked against a source-table reference model.
module tb_pc_new_mux;

    logic       clk;
    logic       rst_n;
    logic       pc_en;
    logic       pc_src;
    logic [1:0] pc_in_sel;
    logic [7:0] pc_plus_1;
    logic [7:0] interrupt_addr;
    logic [7:0] stack_addr;
    logic [7:0] branch_addr;
    logic [7:0] reset_addr;
    logic [7:0] pc_new;
    logic [7:0] pc;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_pc;
    logic [7:0] exp_next;

    pc_new_mux #(
        .ADDR_W       (8),
        .PC_RESET_VAL (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_en          (pc_en),
        .pc_src         (pc_src),
        .pc_in_sel      (pc_in_sel),
        .pc_plus_1      (pc_plus_1),
        .interrupt_addr (interrupt_addr),
        .stack_addr     (stack_addr),
        .branch_addr    (branch_addr),
        .reset_addr     (reset_addr),
        .pc_new         (pc_new),
        .pc             (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: redirect sources form a table indexed by the select code.
    function automatic logic [7:0] model_next(input logic src, input logic [1:0] sel,
                                              input logic [7:0] p1, input logic [7:0] ia,
                                              input logic [7:0] sa, input logic [7:0] ba,
                                              input logic [7:0] ra);
        logic [7:0] redirect [4];
        redirect[0] = ia;
        redirect[1] = sa;
        redirect[2] = ba;
        redirect[3] = ra;
        return src ? redirect[sel] : p1;
    endfunction

    task automatic applyStimulus(input logic en, input logic src, input logic [1:0] sel,
                                 input logic [7:0] p1, input logic [7:0] ia,
                                 input logic [7:0] sa, input logic [7:0] ba,
                                 input logic [7:0] ra);
        pc_en          = en;
        pc_src         = src;
        pc_in_sel      = sel;
        pc_plus_1      = p1;
        interrupt_addr = ia;
        stack_addr     = sa;
        branch_addr    = ba;
        reset_addr     = ra;
        exp_next       = model_next(src, sel, p1, ia, sa, ba, ra);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, mirroring the register load in the model, then check pc.
    task automatic clockAndCheck(input string tag);
        @(posedge clk);
        if (!rst_n)     exp_pc = 8'h00;
        else if (pc_en) exp_pc = exp_next;
        #1;
        checkOutput(tag, pc, exp_pc);
    endtask

    initial begin
        rst_n  = 1'b0;
        exp_pc = 8'h00;
        applyStimulus(1'b1, 1'b0, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        checkOutput("reset_pc", pc, 8'h00);
        checkOutput("seq_sel00", pc_new, 8'h10);

        // Combinational path stays live during reset.
        applyStimulus(1'b1, 1'b0, 2'b11, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
        #1 checkOutput("seq_sel11", pc_new, 8'h10);
        applyStimulus(1'b1, 1'b1, 2'b00, 8'h10, 8'hFF, 8'h00, 8'h00, 8'h00);
        #1 checkOutput("interrupt", pc_new, 8'hFF);
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h10, 8'hFF, 8'h20, 8'h00, 8'h00);
        #1 checkOutput("stack", pc_new, 8'h20);
        applyStimulus(1'b1, 1'b1, 2'b10, 8'h10, 8'hFF, 8'h20, 8'h30, 8'h00);
        #1 checkOutput("branch", pc_new, 8'h30);
        applyStimulus(1'b1, 1'b1, 2'b11, 8'hxx, 8'hxx, 8'hxx, 8'hxx, 8'h40);
        #1 checkOutput("reset_vec", pc_new, 8'h40);

        // Enabled edge while reset held: reset wins.
        clockAndCheck("reset_wins");

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'b10, 8'h10, 8'hFF, 8'h20, 8'h30, 8'h40);
        clockAndCheck("load_branch");
        checkOutput("load_branch_abs", pc, 8'h30);

        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'b10, 8'h10, 8'hFF, 8'h20, 8'h55, 8'h40);
        clockAndCheck("stall_hold");
        checkOutput("stall_hold_abs", pc, 8'h30);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_pc = 8'h00;
        checkOutput("async_rst_pc", pc, 8'h00);
        checkOutput("async_rst_pc_new", pc_new, 8'h55);
        applyStimulus(1'b1, 1'b0, 2'b01, 8'h77, 8'hFF, 8'h20, 8'h55, 8'h40);
        #1 checkOutput("rst_tracking", pc_new, 8'h77);
        #1 rst_n = 1'b1;
        clockAndCheck("post_rst_load");

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
                          8'($urandom), 8'($urandom), 8'($urandom),
                          8'($urandom), 8'($urandom));
            #1 checkOutput("rand_pc_new", pc_new, exp_next);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                #1;
                exp_pc = 8'h00;
                checkOutput("rand_async_rst", pc, exp_pc);
                checkOutput("rand_rst_pc_new", pc_new, exp_next);
                #1 rst_n = 1'b1;
            end
            clockAndCheck("rand_pc");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_new_mux.md
# pc_new_mux

Next-program-counter selection block for the 8-bit pipelined processor's fetch stage. Combinationally chooses the next PC from the sequential, interrupt, stack-return, branch and reset-vector sources. Also holds the architectural PC in a register that loads the selected value each enabled clock edge. The combinational `pc_new` path never depends on the clock or reset, so the block works even when only the mux function is used.

## Interface
Parameters:
- `ADDR_W`, 8, width of all address buses and of the PC register.
- `PC_RESET_VAL`, 8'h00, value loaded into the PC register while reset is asserted.

Ports:
- `clk`  input  1  single system clock; the PC register updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `pc_en`  input  1  PC register load enable (low = stall/hold).
- `pc_src`  input  1  0 = sequential flow, 1 = redirect selected by `pc_in_sel`.
- `pc_in_sel`  input  2  redirect source select; only meaningful when `pc_src` = 1.
- `pc_plus_1`  input  ADDR_W  current PC + 1 (sequential address).
- `interrupt_addr`  input  ADDR_W  interrupt vector.
- `stack_addr`  input  ADDR_W  return address popped from the stack (RET/RTI).
- `branch_addr`  input  ADDR_W  branch/jump/call target.
- `reset_addr`  input  ADDR_W  reset vector (software reset path).
- `pc_new`  output  ADDR_W  selected next PC (combinational).
- `pc`  output  ADDR_W  registered current PC.

## Operation
- Selection (pure combinational, no latches, fully specified for every input combination):
  - `pc_src` = 0 → `pc_new` = `pc_plus_1`, regardless of `pc_in_sel`.
  - `pc_src` = 1, `pc_in_sel` = 2'b00 → `interrupt_addr`.
  - `pc_src` = 1, `pc_in_sel` = 2'b01 → `stack_addr`.
  - `pc_src` = 1, `pc_in_sel` = 2'b10 → `branch_addr`.
  - `pc_src` = 1, `pc_in_sel` = 2'b11 → `reset_addr`.
- Unselected inputs may be X/undriven without affecting `pc_new`.
- If `pc_src` or `pc_in_sel` is X/Z, `pc_new` is X. Silent defaulting to a valid source is forbidden.
- No arithmetic: values pass through unmodified at full ADDR_W width. No wrap handling is needed here; the upstream `pc_plus_1` generator handles wrap (8'hFF + 1 = 8'h00).
- PC register:
  - `rst_n` low → `pc` = PC_RESET_VAL immediately.
  - Otherwise, rising `clk` with `pc_en` = 1 → `pc` ← `pc_new`.
  - `pc_en` = 0 → `pc` holds.
- `pc_new` is not gated by `rst_n` or `pc_en`. It always reflects the current select and source inputs, including during reset.

## Timing
- `pc_new`: zero-cycle combinational path from all inputs except `clk`/`rst_n`. It settles within the same evaluation step after any input change.
- `pc`: one-cycle latency. The value of `pc_new` sampled at rising edge N appears on `pc` after edge N.
- Reset assertion is asynchronous and takes effect mid-cycle. Release is sampled normally: the first load happens on the first rising edge with `rst_n` high and `pc_en` high.
- Reset and an enabled edge occurring together → reset wins, and `pc` = PC_RESET_VAL.
- Reset output values: `pc` = PC_RESET_VAL. `pc_new` has no reset value (combinational).

## Test plan
- Sequential select: `pc_src`=0, `pc_in_sel`=00, `pc_plus_1`=8'h10 → `pc_new`=8'h10. Repeat with `pc_in_sel`=11 → still 8'h10.
- Interrupt select: `pc_src`=1, `pc_in_sel`=00, `interrupt_addr`=8'hFF → `pc_new`=8'hFF.
- Stack and branch select: `pc_src`=1, `pc_in_sel`=01, `stack_addr`=8'h20 → 8'h20. Then `pc_in_sel`=10, `branch_addr`=8'h30 → 8'h30.
- Reset vector select: `pc_src`=1, `pc_in_sel`=11, `reset_addr`=8'h40 → `pc_new`=8'h40, with the other sources X.
- Register path: hold `rst_n`=0 → `pc`=8'h00. Release, set `pc_en`=1, `pc_src`=1, `pc_in_sel`=10, `branch_addr`=8'h30, clock once → `pc`=8'h30. Set `pc_en`=0, change `branch_addr` to 8'h55, clock → `pc` stays 8'h30.
- Async reset mid-cycle: `pc`=8'h30, drop `rst_n` between edges → `pc`=8'h00 without a clock edge, while `pc_new` keeps tracking the inputs.
